// File: rtl/cla_nibble_subtractor_if.sv
`default_nettype none
// ============================================================================
// cla_nibble_subtractor_if : start/busy/done bus of the nibble-serial subtractor
// Rev 1.0
// ============================================================================
interface cla_nibble_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             overflow;

    modport master (
        output start, a, b, b_in,
        input  busy, done, diff, b_out, overflow
    );

    modport slave (
        input  start, a, b, b_in,
        output busy, done, diff, b_out, overflow
    );
endinterface
`default_nettype wire

// File: rtl/cla_nibble_subtractor.sv
`default_nettype none
// ============================================================================
// cla_nibble_subtractor : a - b - b_in, one 4-bit lookahead slice per clock
// Rev 1.0
// ============================================================================
module cla_nibble_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cla_nibble_subtractor_if.slave  bus
);
    localparam int c_NIBBLES = WIDTH / 4;
    localparam int c_CW      = (c_NIBBLES > 1) ? $clog2(c_NIBBLES) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [c_CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              borrow_q, borrow_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              b_out_q, b_out_d;
    logic              overflow_q, overflow_d;

    logic [c_CW+1:0]   idx;
    logic [3:0]        x, y, g, p, sum;
    logic              c0, c1, c2, c3, c4;

    assign idx = {cnt_q, 2'b00};

    // Subtraction as a + ~b + 1 - borrow: invert the subtrahend nibble and the incoming borrow.
    always_comb begin
        x  = a_q[idx +: 4];
        y  = ~b_q[idx +: 4];
        c0 = ~borrow_q;
        g  = x & y;
        p  = x ^ y;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        sum = p ^ {c3, c2, c1, c0};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        borrow_d   = borrow_q;
        diff_d     = diff_q;
        b_out_d    = b_out_q;
        overflow_d = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_RUN;
                    a_d      = bus.a;
                    b_d      = bus.b;
                    borrow_d = bus.b_in;
                    cnt_d    = '0;
                end
            end
            S_RUN: begin
                diff_d[idx +: 4] = sum;
                borrow_d         = ~c4;
                cnt_d            = cnt_q + 1'b1;
                if (cnt_q == c_LAST) begin
                    state_d    = S_DONE;
                    b_out_d    = ~c4;
                    // sum[3] is the new sign bit of diff on the final nibble.
                    overflow_d = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ sum[3]);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            borrow_q   <= 1'b0;
            diff_q     <= '0;
            b_out_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            borrow_q   <= borrow_d;
            diff_q     <= diff_d;
            b_out_q    <= b_out_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.busy     = (state_q == S_RUN);
    assign bus.done     = (state_q == S_DONE);
    assign bus.diff     = diff_q;
    assign bus.b_out    = b_out_q;
    assign bus.overflow = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_cla_nibble_subtractor.sv
`default_nettype none
// ============================================================================
// tb_cla_nibble_subtractor : directed and random operations against an arithmetic model
// Rev 1.0
// ============================================================================
module tb_cla_nibble_subtractor;
    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cla_nibble_subtractor_if #(.WIDTH(WIDTH)) bus();

    cla_nibble_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {overflow, b_out, diff} from plain wide arithmetic.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic bin);
        logic [16:0] r;
        logic        ovf;
        r   = {1'b0, a} - {1'b0, b} - {16'd0, bin};
        ovf = (a[15] ^ b[15]) & (a[15] ^ r[15]);
        return {ovf, r[16], r[15:0]};
    endfunction

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                         input bit hammer, input string tag);
        logic [17:0] exp;
        int          lat;
        exp = model(a, b, bin);
        @(negedge clk);
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.b_in = bin;
        @(posedge clk);
        @(negedge clk);
        bus.start = hammer;
        bus.a = 16'($urandom); bus.b = 16'($urandom); bus.b_in = 1'($urandom);
        check_eq({tag, "/busy"}, {31'd0, bus.busy}, 32'd1);
        lat = 0;
        for (int k = 1; k <= N + 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            bus.a = 16'($urandom); bus.b = 16'($urandom);
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        check_eq({tag, "/latency"},  lat,                     N);
        check_eq({tag, "/diff"},     {16'd0, bus.diff},       {16'd0, exp[15:0]});
        check_eq({tag, "/b_out"},    {31'd0, bus.b_out},      {31'd0, exp[16]});
        check_eq({tag, "/overflow"}, {31'd0, bus.overflow},   {31'd0, exp[17]});
        @(negedge clk);
        bus.start = 1'b0;
        check_eq({tag, "/done_once"}, {31'd0, bus.done}, 32'd0);
        check_eq({tag, "/idle"},      {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        check_eq({tag, "/no_requeue"}, {30'd0, bus.busy, bus.done}, 32'd0);
        check_eq({tag, "/diff_hold"},  {16'd0, bus.diff},           {16'd0, exp[15:0]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.b_in = 1'b0;
        #2;
        check_eq("reset/busy",     {31'd0, bus.busy},     32'd0);
        check_eq("reset/done",     {31'd0, bus.done},     32'd0);
        check_eq("reset/diff",     {16'd0, bus.diff},     32'd0);
        check_eq("reset/b_out",    {31'd0, bus.b_out},    32'd0);
        check_eq("reset/overflow", {31'd0, bus.overflow}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(16'h1234, 16'h0234, 1'b0, 1'b0, "t1");
        do_op(16'h0000, 16'h0001, 1'b0, 1'b0, "t2");
        do_op(16'h8000, 16'h0001, 1'b0, 1'b0, "t3a");
        do_op(16'h0005, 16'h0003, 1'b1, 1'b0, "t4a");
        do_op(16'h0000, 16'h0000, 1'b1, 1'b0, "t4b");
        do_op(16'h9ABC, 16'h1111, 1'b0, 1'b1, "t5_hammer");
        do_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b0, "t3b");

        // Abort mid-operation with nonzero diff/b_out/overflow left from the previous op.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h4321; bus.b = 16'h1234; bus.b_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6/busy",     {31'd0, bus.busy},     32'd0);
        check_eq("t6/done",     {31'd0, bus.done},     32'd0);
        check_eq("t6/diff",     {16'd0, bus.diff},     32'd0);
        check_eq("t6/b_out",    {31'd0, bus.b_out},    32'd0);
        check_eq("t6/overflow", {31'd0, bus.overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'hC0DE, 16'hBEEF, 1'b1, 1'b0, "t6_after");

        for (int i = 0; i < 40; i++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), bit'($urandom_range(0, 1)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
